// File: rtl/pool_engine_gen.sv
// Parallel max/average pooling engine, NUMBER_OF_UNITS channels per pass.
// Define POOL_ENGINE_RELU_EN to clamp negative results to zero.
module pool_engine_gen #(
    parameter int DATA_WIDTH            = 16,
    parameter int IFM_SIZE              = 10,
    parameter int IFM_DEPTH             = 16,
    parameter int KERNAL_SIZE           = 2,
    parameter int STRIDE                = 2,
    parameter int NUMBER_OF_UNITS       = 4,
    parameter int IFM_SIZE_NEXT         = (IFM_SIZE - KERNAL_SIZE) / STRIDE + 1,
    parameter int GROUPS                = (IFM_DEPTH + NUMBER_OF_UNITS - 1) / NUMBER_OF_UNITS,
    parameter int ADDRESS_SIZE_IFM      = $clog2(IFM_SIZE * IFM_SIZE),
    parameter int ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT)
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     start_from_previous,
    input  logic                                     pool_mode,
    output logic                                     ifm_enable_read,
    output logic [ADDRESS_SIZE_IFM-1:0]              ifm_address_read,
    input  logic [NUMBER_OF_UNITS*DATA_WIDTH-1:0]    data_in,
    output logic [$clog2(GROUPS+1)-1:0]              ifm_sel_read,
    output logic                                     end_to_previous,
    input  logic                                     conv_ready,
    input  logic                                     end_from_next,
    output logic                                     ifm_enable_write_next,
    output logic [ADDRESS_SIZE_NEXT_IFM-1:0]         ifm_address_write_next,
    output logic [NUMBER_OF_UNITS*DATA_WIDTH-1:0]    data_out,
    output logic [$clog2(GROUPS+1)-1:0]              ifm_sel_next,
    output logic                                     start_to_next
);

    localparam int K2  = KERNAL_SIZE * KERNAL_SIZE;
    localparam int LK  = $clog2(KERNAL_SIZE);
    localparam int LK2 = $clog2(K2);
    localparam int PW  = $clog2(K2 + 1);
    localparam int OW  = $clog2(IFM_SIZE_NEXT) + 1;
    localparam int SW  = $clog2(GROUPS + 1);
    localparam int AW  = DATA_WIDTH + LK2;
    localparam int NU  = NUMBER_OF_UNITS;
    localparam int DW  = DATA_WIDTH;

    typedef enum logic [2:0] {
        IDLE, WAIT_NEXT, READ, DRAIN, GROUP_DONE
    } state_t;

    state_t state, state_nxt;

    logic [PW-1:0] p;
    logic [PW-1:0] kx, ky;
    logic [OW-1:0] ox, oy;
    logic [SW-1:0] group;
    logic          mode;
    logic          next_busy;
    logic          win_end, last_win, last_group;

    logic signed [AW-1:0] acc     [NU];
    logic signed [AW-1:0] sext    [NU];
    logic signed [AW-1:0] nxt_acc [NU];
    logic signed [DW-1:0] res     [NU];
    logic [NU*DW-1:0]     res_flat;

    assign win_end    = (state == READ) && (p == PW'(K2));
    assign last_win   = (ox == OW'(IFM_SIZE_NEXT - 1)) &&
                        (oy == OW'(IFM_SIZE_NEXT - 1));
    assign last_group = (group == SW'(GROUPS - 1));
    assign kx         = p & PW'(KERNAL_SIZE - 1);
    assign ky         = p >> LK;
    assign ifm_sel_read = group;
    assign ifm_sel_next = group;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:       if (start_from_previous) state_nxt = WAIT_NEXT;
            WAIT_NEXT:  if (conv_ready && !next_busy) state_nxt = READ;
            READ:       if (win_end && last_win) state_nxt = DRAIN;
            DRAIN:      state_nxt = GROUP_DONE;
            GROUP_DONE: state_nxt = last_group ? IDLE : WAIT_NEXT;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ifm_enable_read = 1'b0;
        start_to_next   = 1'b0;
        end_to_previous = 1'b0;
        unique case (state)
            READ:       ifm_enable_read = (p < PW'(K2));
            GROUP_DONE: begin
                start_to_next   = 1'b1;
                end_to_previous = last_group;
            end
            default: ;
        endcase
    end

    always_comb begin
        ifm_address_read = ADDRESS_SIZE_IFM'(
            (32'(oy) * STRIDE + 32'(ky)) * IFM_SIZE +
            32'(ox) * STRIDE + 32'(kx));
    end

    // Sample i of a window lands in phase i+1; phase K2 holds the last one.
    always_comb begin
        res_flat = '0;
        for (int u = 0; u < NU; u++) begin
            sext[u] = AW'(signed'(data_in[u*DW +: DW]));
            if (p == PW'(1))
                nxt_acc[u] = sext[u];
            else if (mode)
                nxt_acc[u] = acc[u] + sext[u];
            else
                nxt_acc[u] = (sext[u] > acc[u]) ? sext[u] : acc[u];
            res[u] = mode ? DW'(nxt_acc[u] >>> LK2) : DW'(nxt_acc[u]);
`ifdef POOL_ENGINE_RELU_EN
            if (res[u] < 0) res[u] = '0;
`endif
            res_flat[u*DW +: DW] = res[u];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p                      <= '0;
            ox                     <= '0;
            oy                     <= '0;
            group                  <= '0;
            mode                   <= 1'b0;
            next_busy              <= 1'b0;
            ifm_enable_write_next  <= 1'b0;
            ifm_address_write_next <= '0;
            data_out               <= '0;
            for (int u = 0; u < NU; u++) acc[u] <= '0;
        end else begin
            ifm_enable_write_next <= win_end;
            if (state == IDLE && start_from_previous) begin
                mode  <= pool_mode;
                group <= '0;
                ox    <= '0;
                oy    <= '0;
                p     <= '0;
            end
            if (state == READ) begin
                if (p != '0)
                    for (int u = 0; u < NU; u++) acc[u] <= nxt_acc[u];
                if (win_end) begin
                    p        <= '0;
                    data_out <= res_flat;
                    ifm_address_write_next <= ADDRESS_SIZE_NEXT_IFM'(
                        32'(oy) * IFM_SIZE_NEXT + 32'(ox));
                    if (ox == OW'(IFM_SIZE_NEXT - 1)) begin
                        ox <= '0;
                        oy <= (oy == OW'(IFM_SIZE_NEXT - 1)) ? '0 : oy + 1'b1;
                    end else begin
                        ox <= ox + 1'b1;
                    end
                end else begin
                    p <= p + 1'b1;
                end
            end
            if (state == GROUP_DONE && !last_group) group <= group + 1'b1;
            // A set in GROUP_DONE beats a simultaneous release.
            if (state == GROUP_DONE) next_busy <= 1'b1;
            else if (end_from_next)  next_busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pool_engine_gen.sv
// Scoreboard bench for pool_engine_gen: 4x4 map, K=2, S=1, 6 channels on 4 units.
// Expected reads and writes are queued at stimulus time and popped by a monitor.
module tb_pool_engine_gen;

    localparam int DW  = 16;
    localparam int SZ  = 4;
    localparam int K   = 2;
    localparam int S   = 1;
    localparam int NU  = 4;
    localparam int DEP = 6;
    localparam int SN  = (SZ - K) / S + 1;
    localparam int G   = (DEP + NU - 1) / NU;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start_from_previous = 1'b0;
    logic          pool_mode = 1'b0;
    logic          ifm_enable_read;
    logic [3:0]    ifm_address_read;
    logic [NU*DW-1:0] data_in = '0;
    logic [1:0]    ifm_sel_read;
    logic          end_to_previous;
    logic          conv_ready = 1'b0;
    logic          end_from_next = 1'b0;
    logic          ifm_enable_write_next;
    logic [3:0]    ifm_address_write_next;
    logic [NU*DW-1:0] data_out;
    logic [1:0]    ifm_sel_next;
    logic          start_to_next;

    pool_engine_gen #(
        .DATA_WIDTH(DW), .IFM_SIZE(SZ), .IFM_DEPTH(DEP),
        .KERNAL_SIZE(K), .STRIDE(S), .NUMBER_OF_UNITS(NU)
    ) dut (
        .clk(clk), .reset(reset),
        .start_from_previous(start_from_previous), .pool_mode(pool_mode),
        .ifm_enable_read(ifm_enable_read), .ifm_address_read(ifm_address_read),
        .data_in(data_in), .ifm_sel_read(ifm_sel_read),
        .end_to_previous(end_to_previous), .conv_ready(conv_ready),
        .end_from_next(end_from_next),
        .ifm_enable_write_next(ifm_enable_write_next),
        .ifm_address_write_next(ifm_address_write_next),
        .data_out(data_out), .ifm_sel_next(ifm_sel_next),
        .start_to_next(start_to_next)
    );

    always #5 clk = ~clk;

    typedef struct { int g; int a; } rd_t;
    typedef struct { int g; int a; logic [NU*DW-1:0] d; } wr_t;

    rd_t exp_rd[$];
    wr_t exp_wr[$];

    logic signed [DW-1:0] mem [0:1][0:NU-1][0:SZ*SZ-1];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rd_count = 0;
    int rd_in_grp = 0, wr_in_grp = 0, grp_seen = 0;
    int first_rd = 0, last_wr = 0;
    bit mon_en = 1'b0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ifm_enable_read)
            for (int u = 0; u < NU; u++)
                data_in[u*DW +: DW] <= mem[ifm_sel_read[0]][u][ifm_address_read];
    end

    always @(negedge clk) begin
        if (mon_en && reset) begin
            if (ifm_enable_read) begin
                rd_t e;
                if (rd_in_grp == 0) first_rd = cyc;
                rd_in_grp++;
                rd_count++;
                if (exp_rd.size() == 0) check("rd_extra", 1, 0);
                else begin
                    e = exp_rd.pop_front();
                    check("rd_addr", 64'(ifm_address_read), 64'(e.a));
                    check("rd_sel", 64'(ifm_sel_read), 64'(e.g));
                end
            end
            if (ifm_enable_write_next) begin
                wr_t w;
                if (wr_in_grp == 0) check("wr_latency", 64'(cyc - first_rd), 5);
                else                check("wr_period", 64'(cyc - last_wr), 5);
                last_wr = cyc;
                wr_in_grp++;
                if (exp_wr.size() == 0) check("wr_extra", 1, 0);
                else begin
                    w = exp_wr.pop_front();
                    check("wr_addr", 64'(ifm_address_write_next), 64'(w.a));
                    check("wr_sel", 64'(ifm_sel_next), 64'(w.g));
                    check("wr_data", data_out, w.d);
                end
            end
            if (start_to_next) begin
                check("stn_after_wr", 64'(cyc - last_wr), 1);
                check("wr_per_grp", 64'(wr_in_grp), 64'(SN * SN));
                check("etp_with_stn", 64'(end_to_previous), 64'(grp_seen == G - 1));
                grp_seen++;
                wr_in_grp = 0;
                rd_in_grp = 0;
            end else if (end_to_previous) begin
                check("etp_alone", 1, 0);
            end
        end
    end

    function automatic logic [DW-1:0] pool(int g, int u, int oy, int ox, bit mode);
        int s, m, v, r;
        s = 0;
        m = 0;
        for (int ky = 0; ky < K; ky++)
            for (int kx = 0; kx < K; kx++) begin
                v = int'(mem[g][u][(oy*S+ky)*SZ + ox*S + kx]);
                if ((ky == 0 && kx == 0) || v > m) m = v;
                s += v;
            end
        r = mode ? (s >>> 2) : m;
`ifdef POOL_ENGINE_RELU_EN
        if (r < 0) r = 0;
`endif
        return DW'(r);
    endfunction

    task automatic fill(input int kind);
        for (int g = 0; g < 2; g++)
            for (int u = 0; u < NU; u++)
                for (int a = 0; a < SZ*SZ; a++) begin
                    if (kind == 0)      mem[g][u][a] = DW'(a + 16*u + 64*g);
                    else if (kind == 1) mem[g][u][a] = DW'($urandom_range(0, 65535));
                    else                mem[g][u][a] = DW'(int'($urandom_range(0, 400)) - 200);
                end
    endtask

    task automatic set_win(input int u, input int a0, input int a1,
                           input int a2, input int a3);
        mem[0][u][0] = DW'(a0);
        mem[0][u][1] = DW'(a1);
        mem[0][u][4] = DW'(a2);
        mem[0][u][5] = DW'(a3);
    endtask

    task automatic build(input bit mode);
        rd_t r;
        wr_t w;
        for (int g = 0; g < G; g++)
            for (int oy = 0; oy < SN; oy++)
                for (int ox = 0; ox < SN; ox++) begin
                    for (int ky = 0; ky < K; ky++)
                        for (int kx = 0; kx < K; kx++) begin
                            r.g = g;
                            r.a = (oy*S+ky)*SZ + ox*S + kx;
                            exp_rd.push_back(r);
                        end
                    w.g = g;
                    w.a = oy*SN + ox;
                    for (int u = 0; u < NU; u++)
                        w.d[u*DW +: DW] = pool(g, u, oy, ox, mode);
                    exp_wr.push_back(w);
                end
    endtask

    task automatic run_pass(input bit mode, input int hold,
                            input int busy_wait, input bit poke);
        int r0;
        bit found;
        build(mode);
        grp_seen = 0;
        wr_in_grp = 0;
        rd_in_grp = 0;
        conv_ready = (hold == 0);
        @(negedge clk);
        pool_mode = mode;
        start_from_previous = 1'b1;
        @(negedge clk);
        start_from_previous = 1'b0;
        pool_mode = ~mode;
        if (hold > 0) begin
            r0 = rd_count;
            repeat (hold) @(negedge clk);
            check("ready_hold_reads", 64'(rd_count - r0), 0);
            conv_ready = 1'b1;
        end
        if (poke) begin
            repeat (6) @(negedge clk);
            start_from_previous = 1'b1;
            @(negedge clk);
            start_from_previous = 1'b0;
        end
        for (int g = 0; g < G; g++) begin
            found = 1'b0;
            for (int c = 0; c < 500 && !found; c++) begin
                if (start_to_next) found = 1'b1;
                else @(negedge clk);
            end
            if (!found) check("stn_timeout", 0, 1);
            r0 = rd_count;
            @(negedge clk);
            repeat (busy_wait) @(negedge clk);
            if (busy_wait > 0 && g < G - 1)
                check("busy_hold_reads", 64'(rd_count - r0), 0);
            end_from_next = 1'b1;
            @(negedge clk);
            end_from_next = 1'b0;
        end
        repeat (5) @(negedge clk);
        check("rd_left", 64'(exp_rd.size()), 0);
        check("wr_left", 64'(exp_wr.size()), 0);
        check("groups_seen", 64'(grp_seen), 64'(G));
    endtask

    initial begin
        int strobes;
        repeat (3) @(negedge clk);
        check("rst_rd_en", 64'(ifm_enable_read), 0);
        check("rst_rd_addr", 64'(ifm_address_read), 0);
        check("rst_wr_en", 64'(ifm_enable_write_next), 0);
        check("rst_wr_addr", 64'(ifm_address_write_next), 0);
        check("rst_data_out", data_out, 0);
        check("rst_sel", 64'({ifm_sel_read, ifm_sel_next}), 0);
        check("rst_pulses", 64'({start_to_next, end_to_previous}), 0);
        reset = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        fill(0);
        run_pass(1'b0, 0, 0, 1'b0);

        fill(1);
        set_win(0, -3, -1, 2, -4);
        set_win(1, 1, 1, 1, 2);
        run_pass(1'b1, 0, 0, 1'b0);

        fill(2);
        set_win(2, -5, -2, -9, -1);
        run_pass(1'b0, 20, 15, 1'b1);

        mon_en = 1'b0;
        fill(2);
        conv_ready = 1'b1;
        @(negedge clk);
        start_from_previous = 1'b1;
        @(negedge clk);
        start_from_previous = 1'b0;
        repeat (12) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_rd_en", 64'(ifm_enable_read), 0);
        check("abort_wr_en", 64'(ifm_enable_write_next), 0);
        check("abort_pulses", 64'({start_to_next, end_to_previous}), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        strobes = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            strobes += int'(ifm_enable_read) + int'(ifm_enable_write_next);
        end
        check("post_abort_idle", 64'(strobes), 0);
        exp_rd.delete();
        exp_wr.delete();
        mon_en = 1'b1;
        run_pass(1'b1, 0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
